// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared types and the level-field helper for the LED fader.
package led_pwm_pkg;
  typedef enum logic [1:0] {HOLD, UP, DOWN} fade_state_t;
  typedef enum logic {MODE_SD = 1'b0, MODE_CMP = 1'b1} pwm_mode_t;
  localparam int MAX_W = 8;
  function automatic logic [MAX_W-1:0] lvl_field(input logic [255:0] v, input int i, input int w);
    logic [255:0] s;
    s = v >> (i * w);
    return MAX_W'(s) & MAX_W'((1 << w) - 1);
  endfunction
endpackage

// File: rtl/led_pwm_chan.sv
// led_pwm_chan: one channel - target register, fade FSM, sigma-delta accumulator and output mux.
module led_pwm_chan
  import led_pwm_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] cnt,
  input  pwm_mode_t    mode,
  input  logic [W-1:0] level,
  output logic         led,
  output logic         busy
);
  logic [W-1:0] tgt_q, cur_q, cur_d;
  logic [W:0] acc_q, acc_d;
  fade_state_t state_q, state_d;
  logic led_q, led_d;
  always_comb begin
    state_d = cur_q == tgt_q ? HOLD : cur_q < tgt_q ? UP : DOWN;
    cur_d = !tick ? cur_q : state_d == UP ? cur_q + 1'b1 : state_d == DOWN ? cur_q - 1'b1 : cur_q;
    acc_d = {1'b0, acc_q[W-1:0]} + {1'b0, cur_q};
    // both modulators always run; mode only picks which bit reaches the pin
    led_d = mode == MODE_CMP ? cnt < cur_q : acc_d[W];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q <= '0;
      cur_q <= '0;
      acc_q <= '0;
      state_q <= HOLD;
      led_q <= 1'b0;
    end else begin
      tgt_q <= level;
      cur_q <= cur_d;
      acc_q <= acc_d;
      state_q <= state_d;
      led_q <= led_d;
    end
  end
  assign led = led_q;
  assign busy = state_q != HOLD;
endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: multi-channel LED fader with shared prescaler, PWM counter and mode register.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int CH = 4,
  parameter int W = 4,
  parameter int FADE_DIV = 1024
) (
  input  logic            FPGA_CLK,
  input  logic            FPGA_RST,
  input  logic [CH*W-1:0] F_LEVEL,
  input  logic            F_MODE,
  output logic [CH-1:0]   F_LED,
  output logic [CH-1:0]   F_BUSY
);
  localparam int PW = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0] cnt_q, cnt_d;
  pwm_mode_t mode_q, mode_d;
  logic tick;
  always_comb begin
    tick = pre_q == PW'(FADE_DIV - 1);
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = cnt_q + 1'b1;
    mode_d = pwm_mode_t'(F_MODE);
  end
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      pre_q <= '0;
      cnt_q <= '0;
      mode_q <= MODE_SD;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
    end
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    led_pwm_chan #(.W(W)) u_ch (
      .clk  (FPGA_CLK),
      .rst  (FPGA_RST),
      .tick (tick),
      .cnt  (cnt_q),
      .mode (mode_q),
      .level(W'(lvl_field(256'(F_LEVEL), i, W))),
      .led  (F_LED[i]),
      .busy (F_BUSY[i])
    );
  end
endmodule
